// File: rtl/clefia_pkg.sv
// Shared definitions for the CLEFIA-128 key schedule: controller state codes,
// schedule dimensions, and the CON table index width used by the table and datapath.
package clefia_pkg;

    localparam int GFN128_ROUNDS = 12;
    localparam int RK128_GROUPS  = 9;
    localparam int CON_IDX_W     = 4;
    localparam int CNT_W         = 4;
    localparam int STATE_W       = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_GFN    = 3'd2;
    localparam state_t ST_CAPT   = 3'd3;
    localparam state_t ST_EXPAND = 3'd4;
    localparam state_t ST_DONE   = 3'd5;

    // The round counter is zero-based internally; the CON table is indexed 1..GFN rounds.
    function automatic logic [CON_IDX_W-1:0] conIndex(input logic [CNT_W-1:0] roundIdx);
        return CON_IDX_W'(roundIdx) + CON_IDX_W'(1);
    endfunction

endpackage

// File: rtl/clefia_step_cnt.sv
// Two-level step counter: a sub-cycle counter that ticks every SUB_MAX+1 cycles and an
// index counter that advances on each tick. Used for both GFN rounds and expansion groups.
module clefia_step_cnt #(
    parameter int CNT_W   = 4,
    parameter int SUB_MAX = 0,
    parameter int IDX_MAX = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] idx_o,
    output logic             tick_o,
    output logic             last_o
);

    localparam logic [CNT_W-1:0] SUB_MAX_C = CNT_W'(SUB_MAX);
    localparam logic [CNT_W-1:0] IDX_MAX_C = CNT_W'(IDX_MAX);

    logic [CNT_W-1:0] sub_q;
    logic [CNT_W-1:0] sub_d;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_d;
    logic             tick;

    assign tick   = (sub_q == SUB_MAX_C);
    assign tick_o = tick;
    assign last_o = tick && (idx_q == IDX_MAX_C);
    assign idx_o  = idx_q;

    // Next-count logic: both counters wrap at their maxima so neither can run past its range.
    always_comb begin
        sub_d = sub_q;
        idx_d = idx_q;
        if (clear_i) begin
            sub_d = '0;
            idx_d = '0;
        end else if (en_i) begin
            if (tick) begin
                sub_d = '0;
                idx_d = (idx_q == IDX_MAX_C) ? '0 : idx_q + CNT_W'(1);
            end else begin
                sub_d = sub_q + CNT_W'(1);
            end
        end
    end

    // Count registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sub_q <= '0;
            idx_q <= '0;
        end else begin
            sub_q <= sub_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/clefia_key_sched_ctrl.sv
// CLEFIA-128 key schedule sequencer. Loads K into the GFN datapath, steps it through
// the GFN rounds while indexing the CON table, captures L, then drives the round-key
// expansion groups before pulsing done. All outputs are decoded from registered state.
module clefia_key_sched_ctrl
    import clefia_pkg::*;
#(
    parameter int ROUND_CYC  = 1,
    parameter int GFN_ROUNDS = GFN128_ROUNDS,
    parameter int RK_GROUPS  = RK128_GROUPS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic                 ready_o,
    output logic [CON_IDX_W-1:0] con_round_o,
    output logic                 gfn_load_o,
    output logic                 gfn_step_o,
    output logic                 gfn_last_o,
    output logic                 l_capture_o,
    output logic                 rk_we_o,
    output logic [3:0]           rk_group_o,
    output logic                 rk_xor_k_o,
    output logic                 sigma_step_o,
    output logic                 done_o
);

    state_t           state_q;
    state_t           state_d;

    logic             inGfn;
    logic             inExpand;
    logic [CNT_W-1:0] gfnIdx;
    logic             gfnTick;
    logic             gfnLast;
    logic [CNT_W-1:0] rkIdx;
    logic             rkTick;
    logic             rkLast;

    assign inGfn    = (state_q == ST_GFN);
    assign inExpand = (state_q == ST_EXPAND);

    clefia_step_cnt #(
        .CNT_W   (CNT_W),
        .SUB_MAX (ROUND_CYC - 1),
        .IDX_MAX (GFN_ROUNDS - 1)
    ) u_gfn_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (!inGfn),
        .en_i    (inGfn),
        .idx_o   (gfnIdx),
        .tick_o  (gfnTick),
        .last_o  (gfnLast)
    );

    clefia_step_cnt #(
        .CNT_W   (CNT_W),
        .SUB_MAX (0),
        .IDX_MAX (RK_GROUPS - 1)
    ) u_rk_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (!inExpand),
        .en_i    (inExpand),
        .idx_o   (rkIdx),
        .tick_o  (rkTick),
        .last_o  (rkLast)
    );

    // Phase sequencing; start is only honoured in IDLE and unknown codes fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_GFN;
            ST_GFN:    if (gfnLast) state_d = ST_CAPT;
            ST_CAPT:   state_d = ST_EXPAND;
            ST_EXPAND: if (rkLast) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register; reset aborts any schedule in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode from the state and counter registers only.
    always_comb begin
        ready_o      = 1'b0;
        con_round_o  = '0;
        gfn_load_o   = 1'b0;
        gfn_step_o   = 1'b0;
        gfn_last_o   = 1'b0;
        l_capture_o  = 1'b0;
        rk_we_o      = 1'b0;
        rk_group_o   = '0;
        rk_xor_k_o   = 1'b0;
        sigma_step_o = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            ST_IDLE: ready_o = 1'b1;
            ST_LOAD: gfn_load_o = 1'b1;
            ST_GFN: begin
                con_round_o = conIndex(gfnIdx);
                gfn_step_o  = gfnTick;
                gfn_last_o  = gfnLast;
            end
            ST_CAPT: l_capture_o = 1'b1;
            ST_EXPAND: begin
                rk_we_o      = rkTick;
                sigma_step_o = rkTick;
                rk_group_o   = 4'(rkIdx);
                rk_xor_k_o   = rkIdx[0];
            end
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_clefia_key_sched_ctrl.sv
// Directed testbench for the CLEFIA-128 key schedule sequencer. Two instances run side by
// side: one at the default single-cycle round latency and one with three cycles per round.
module tb_clefia_key_sched_ctrl;

    logic clk;
    logic rst;
    logic start1;
    logic start3;

    logic       ready1, gfnLoad1, gfnStep1, gfnLast1, lCapture1, rkWe1, rkXorK1, sigmaStep1, done1;
    logic [3:0] conRound1, rkGroup1;
    logic       ready3, gfnLoad3, gfnStep3, gfnLast3, lCapture3, rkWe3, rkXorK3, sigmaStep3, done3;
    logic [3:0] conRound3, rkGroup3;

    logic [16:0] vec1;
    logic [16:0] vec3;

    int checks   = 0;
    int failures = 0;

    localparam logic [16:0] IDLE_VEC = 17'h10000;

    clefia_key_sched_ctrl #(.ROUND_CYC(1)) dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start1),
        .ready_o      (ready1),
        .con_round_o  (conRound1),
        .gfn_load_o   (gfnLoad1),
        .gfn_step_o   (gfnStep1),
        .gfn_last_o   (gfnLast1),
        .l_capture_o  (lCapture1),
        .rk_we_o      (rkWe1),
        .rk_group_o   (rkGroup1),
        .rk_xor_k_o   (rkXorK1),
        .sigma_step_o (sigmaStep1),
        .done_o       (done1)
    );

    clefia_key_sched_ctrl #(.ROUND_CYC(3)) dut3 (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start3),
        .ready_o      (ready3),
        .con_round_o  (conRound3),
        .gfn_load_o   (gfnLoad3),
        .gfn_step_o   (gfnStep3),
        .gfn_last_o   (gfnLast3),
        .l_capture_o  (lCapture3),
        .rk_we_o      (rkWe3),
        .rk_group_o   (rkGroup3),
        .rk_xor_k_o   (rkXorK3),
        .sigma_step_o (sigmaStep3),
        .done_o       (done3)
    );

    assign vec1 = {ready1, conRound1, gfnLoad1, gfnStep1, gfnLast1, lCapture1, rkWe1,
                   rkGroup1, rkXorK1, sigmaStep1, done1};
    assign vec3 = {ready3, conRound3, gfnLoad3, gfnStep3, gfnLast3, lCapture3, rkWe3,
                   rkGroup3, rkXorK3, sigmaStep3, done3};

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected output vector for cycle c of a schedule, straight from the published timeline.
    function automatic logic [16:0] expVec(input int c, input int rc);
        logic       rdy  = 1'b0;
        logic [3:0] con  = 4'd0;
        logic       load = 1'b0;
        logic       step = 1'b0;
        logic       lst  = 1'b0;
        logic       capt = 1'b0;
        logic       we   = 1'b0;
        logic [3:0] grp  = 4'd0;
        logic       xk   = 1'b0;
        logic       sig  = 1'b0;
        logic       dn   = 1'b0;
        int         gr   = 12 * rc;
        if (c == 0) begin
            load = 1'b1;
        end else if (c >= 1 && c <= gr) begin
            con  = 4'((c - 1) / rc + 1);
            step = (((c - 1) % rc) == rc - 1);
            lst  = step && (((c - 1) / rc) == 11);
        end else if (c == gr + 1) begin
            capt = 1'b1;
        end else if (c >= gr + 2 && c <= gr + 10) begin
            we  = 1'b1;
            sig = 1'b1;
            grp = 4'(c - gr - 2);
            xk  = grp[0];
        end else if (c == gr + 11) begin
            dn = 1'b1;
        end else begin
            rdy = 1'b1;
        end
        return {rdy, con, load, step, lst, capt, we, grp, xk, sig, dn};
    endfunction

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive the bench inputs.
    task automatic applyStimulus(input logic s1, input logic s3, input logic r);
        start1 = s1;
        start3 = s3;
        rst    = r;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full schedule on the selected instance, optionally with stray start pulses mid-run and in DONE.
    task automatic runSchedule(input int rc, input bit noisy, input string name, input int expDoneCycle);
        int doneCount = 0;
        int doneCycle = -1;
        int lastCycle = 12 * rc + 13;
        logic [16:0] v;
        applyStimulus(rc == 1, rc == 3, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int c = 0; c <= lastCycle; c++) begin
            v = (rc == 1) ? vec1 : vec3;
            checkOutput($sformatf("%s_c%0d", name, c), 32'(v), 32'(expVec(c, rc)));
            if (v[0]) begin
                doneCount++;
                doneCycle = c;
            end
            if (noisy && (c == 5 || c == 12 * rc + 11)) begin
                applyStimulus(rc == 1, rc == 3, 1'b0);
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0);
            end
            tick();
        end
        checkOutput($sformatf("%s_doneCount", name), 32'(doneCount), 32'd1);
        checkOutput($sformatf("%s_doneCycle", name), 32'(doneCycle), 32'(expDoneCycle));
    endtask

    initial begin
        int doneCount;
        int doneAt[3];

        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("rst_vec1", 32'(vec1), 32'(IDLE_VEC));
        checkOutput("rst_vec3", 32'(vec3), 32'(IDLE_VEC));
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("idle_vec1", 32'(vec1), 32'(IDLE_VEC));

        $display("[TB] single-cycle rounds, done expected at cycle 23");
        runSchedule(1, 1'b0, "rc1", 23);

        $display("[TB] three-cycle rounds, done expected at cycle 47");
        runSchedule(3, 1'b0, "rc3", 47);
        checkOutput("rc1_idle_during_rc3", 32'(vec1), 32'(IDLE_VEC));

        $display("[TB] stray start pulses in GFN and DONE");
        runSchedule(1, 1'b1, "noisy", 23);

        $display("[TB] reset at cycle 7");
        doneCount = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int c = 0; c <= 7; c++) begin
            checkOutput($sformatf("abort_c%0d", c), 32'(vec1), 32'(expVec(c, 1)));
            if (c == 7) applyStimulus(1'b0, 1'b0, 1'b1);
            tick();
        end
        checkOutput("abort_after_rst", 32'(vec1), 32'(IDLE_VEC));
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            if (done1) doneCount++;
            checkOutput($sformatf("abort_idle%0d", c), 32'(vec1), 32'(IDLE_VEC));
        end
        checkOutput("abort_noDone", 32'(doneCount), 32'd0);
        runSchedule(1, 1'b0, "fresh", 23);

        $display("[TB] start held high for 60 cycles");
        doneCount = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        for (int c = 0; c <= 76; c++) begin
            checkOutput($sformatf("held_c%0d", c), 32'(vec1),
                        32'((c < 50) ? expVec(c % 25, 1) : expVec(c - 50, 1)));
            if (done1) begin
                if (doneCount < 3) doneAt[doneCount] = c;
                doneCount++;
            end
            if (c == 59) applyStimulus(1'b0, 1'b0, 1'b0);
            tick();
        end
        checkOutput("held_doneCount", 32'(doneCount), 32'd3);
        checkOutput("held_done0", 32'(doneAt[0]), 32'd23);
        checkOutput("held_done1", 32'(doneAt[1]), 32'd48);
        checkOutput("held_done2", 32'(doneAt[2]), 32'd73);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
